johnson_decoder: RTL and testbench
==================================

# johnson_decoder

Receive-side companion to the team's Johnson counter. Takes an N-bit Johnson-coded word, decodes it to a binary phase index 0..2N-1, and flags illegal codes. It checks that successive valid samples follow the legal shift sequence, runs a lock state machine, and keeps a saturating error count. It sits wherever a Johnson-coded phase crosses a block boundary, for example a sequencer phase bus or a ring-timing monitor.

## Interface
Parameters:
- N, 4, code width; the sequence length is 2N.
- LOCK_COUNT, 3, number of consecutive good transitions needed to enter LOCKED (1..15).
- ALLOW_HOLD, 1, if 1 a repeated identical legal code is not an error; if 0 it is a sequence error.
- PW, $clog2(2N), phase output width (derived, not overridden).

Ports:
- clk, input, 1, single clock; all logic on posedge.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, code is sampled on this cycle.
- code, input, N, Johnson-coded word; bit N-1 is the MSB.
- clear_err, input, 1, synchronous clear of err_count.
- phase, output, PW, decoded phase of the last legal sample.
- phase_valid, output, 1, one-cycle pulse: phase updated from a legal sample.
- illegal, output, 1, one-cycle pulse: sampled code is not a legal Johnson word.
- seq_err, output, 1, one-cycle pulse: a legal code that is not an allowed successor, seen in CHECK or LOCKED.
- wrap, output, 1, one-cycle pulse: in LOCKED, phase advanced from 2N-1 to 0.
- locked, output, 1, level: FSM is in LOCKED.
- err_count, output, 8, saturating count of illegal plus seq_err events.

## Operation
- Legal sequence from all-zeros, using the rule next = {cur[N-2:0], ~cur[N-1]}. For N=4 it is 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then back to 0000.
- Legality test:
  - When code[N-1]=0, the code must equal (1<<k)-1 for some k in 0..N-1.
  - When code[N-1]=1, ~code must equal (1<<z)-1 for some z in 0..N-1.
- Decode:
  - code[N-1]=0 gives phase = k, the count of ones.
  - code[N-1]=1 gives phase = N + z, the count of zeros.
- Allowed successor of phase p is (p+1) mod 2N. Phase p itself is also allowed when ALLOW_HOLD=1.
- Illegal sample: pulse illegal; phase is unchanged; phase_valid=0; FSM goes to HUNT.
- FSM states:
  - HUNT:
    - A legal sample loads phase, clears the good counter and moves to CHECK.
    - An illegal sample stays in HUNT.
  - CHECK:
    - A legal successor increments the good counter.
    - A held code (ALLOW_HOLD=1) leaves the counter unchanged.
    - When the counter reaches LOCK_COUNT, move to LOCKED.
    - A legal non-successor pulses seq_err, reloads phase, clears the counter and stays in CHECK.
    - An illegal sample goes to HUNT.
  - LOCKED:
    - A successor or hold stays in LOCKED.
    - A legal non-successor pulses seq_err, loads phase and goes to CHECK with the counter cleared.
    - An illegal sample goes to HUNT.
- phase_valid pulses for every legal sample in every state, holds included.
- err_count:
  - Adds 1 for each cycle in which illegal or seq_err fires; the two are mutually exclusive by construction.
  - Saturates at 255.
  - clear_err has priority over an increment in the same cycle, so the result is 0.
- in_valid=0: no state change, all pulses are 0, code is ignored.

## Timing
- All outputs are registered. Sample on edge t produces its outputs during cycle t+1, so latency is 1 cycle.
- locked rises in the cycle after the LOCK_COUNT-th good transition is sampled.
- It falls in the cycle after the offending sample, in the same cycle as the seq_err or illegal pulse.
- Back-to-back in_valid is supported at full rate; no backpressure.
- Reset (rst_n=0 at a posedge):
  - phase=0, all pulses=0, locked=0, err_count=0, FSM=HUNT, good counter=0.
  - Applies mid-sequence with no residual state. First sample after release is treated as a HUNT sample.
- wrap is only asserted in LOCKED, on a transition from 2N-1 to 0. It is never asserted on a hold.

## Test plan
- Reset then free-running sequence (N=4, LOCK_COUNT=3): feed 0000, 0001, 0011, 0111 on consecutive cycles.
  - Required: phase 0, 1, 2, 3 with phase_valid each cycle.
  - Required: locked=1 one cycle after 0111 is sampled; err_count=0.
- Wrap: after lock, feed 1000 then 0000.
  - Required: phase 7 then 0, with wrap=1 only on the 0 output cycle.
- Illegal code: while locked, feed 0101.
  - Required next cycle: illegal=1, locked=0, phase unchanged, err_count=1.
  - Then 0011, 0111, 1111, 1110 must re-lock.
- Skip: while locked at phase 2, feed 1111 (phase 4).
  - Required: seq_err=1, phase=4, locked=0, FSM in CHECK, err_count increments.
- Hold: with ALLOW_HOLD=1, repeat 0011 for three cycles while locked; locked stays 1 and there are no errors.
  - With ALLOW_HOLD=0, the repeat gives seq_err=1.
- Saturation and clear:
  - Drive 300 illegal samples; err_count stays at 255.
  - Assert clear_err together with a further illegal sample; err_count becomes 0.
  - Assert rst_n=0 mid-lock; all outputs read zero on the next cycle.

Source files
------------

// File: rtl/johnson_decoder.sv
// Johnson-code receiver: decodes an N-bit Johnson word to a phase index,
// flags illegal codes, checks successor order, tracks lock and counts errors.
module johnson_decoder #(
  parameter  int N          = 4,
  parameter  int LOCK_COUNT = 3,
  parameter  int ALLOW_HOLD = 1,
  localparam int PW         = $clog2(2 * N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [N-1:0]  code,
  input  logic          clear_err,
  output logic [PW-1:0] phase,
  output logic          phase_valid,
  output logic          illegal,
  output logic          seq_err,
  output logic          wrap,
  output logic          locked,
  output logic [7:0]    err_count
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [PW-1:0] LAST_PHASE = PW'(2 * N - 1);
  localparam logic [3:0]    LOCK_TGT   = 4'(LOCK_COUNT);

  state_t        state_q, state_d;
  logic [3:0]    good_q, good_d;
  logic [PW-1:0] phase_d;
  logic          pv_d, ill_d, seq_d, wrap_d;
  logic [7:0]    err_d;

  logic [N-1:0]  therm;
  logic          legal;
  logic [PW-1:0] ones;
  logic [PW-1:0] dec_phase;
  logic [PW-1:0] succ_phase;
  logic          is_succ;
  logic          is_hold;

  // Decode: fold the upper half of the sequence onto a thermometer code so one
  // legality test and one popcount serve both halves.
  always_comb begin
    therm = code[N-1] ? ~code : code;
    legal = ((therm & (therm + N'(1))) == '0);
    ones  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      ones = ones + PW'(therm[i]);
    end
    dec_phase  = code[N-1] ? (PW'(N) + ones) : ones;
    succ_phase = (phase == LAST_PHASE) ? '0 : (phase + PW'(1));
    is_succ    = (dec_phase == succ_phase);
    is_hold    = (ALLOW_HOLD != 0) && (dec_phase == phase);
  end

  // Next-state, phase tracking, pulse generation and error counting.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    phase_d = phase;
    pv_d    = 1'b0;
    ill_d   = 1'b0;
    seq_d   = 1'b0;
    wrap_d  = 1'b0;
    if (in_valid) begin
      if (!legal) begin
        ill_d   = 1'b1;
        state_d = HUNT;
        good_d  = '0;
      end else begin
        pv_d    = 1'b1;
        phase_d = dec_phase;
        unique case (state_q)
          HUNT: begin
            good_d  = '0;
            state_d = CHECK;
          end
          CHECK: begin
            if (is_succ) begin
              good_d = good_q + 4'd1;
              if (good_q + 4'd1 == LOCK_TGT) state_d = LOCKED;
            end else if (!is_hold) begin
              seq_d  = 1'b1;
              good_d = '0;
            end
          end
          LOCKED: begin
            if (is_succ) begin
              wrap_d = (phase == LAST_PHASE);
            end else if (!is_hold) begin
              seq_d   = 1'b1;
              good_d  = '0;
              state_d = CHECK;
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end
    if (clear_err)                           err_d = '0;
    else if ((ill_d || seq_d) && err_count != 8'hFF) err_d = err_count + 8'd1;
    else                                     err_d = err_count;
  end

  // Registered state and outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      good_q      <= '0;
      phase       <= '0;
      phase_valid <= 1'b0;
      illegal     <= 1'b0;
      seq_err     <= 1'b0;
      wrap        <= 1'b0;
      err_count   <= '0;
    end else begin
      state_q     <= state_d;
      good_q      <= good_d;
      phase       <= phase_d;
      phase_valid <= pv_d;
      illegal     <= ill_d;
      seq_err     <= seq_d;
      wrap        <= wrap_d;
      err_count   <= err_d;
    end
  end

  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_johnson_decoder.sv
// Bench for johnson_decoder (N=4, LOCK_COUNT=3): two instances share stimulus,
// one with holds allowed and one without, both checked against a table model.
module tb_johnson_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] code = '0;
  logic       clear_err = 1'b0;

  logic [2:0] phase_o  [2];
  logic       pv_o     [2];
  logic       ill_o    [2];
  logic       seq_o    [2];
  logic       wrap_o   [2];
  logic       lock_o   [2];
  logic [7:0] err_o    [2];

  johnson_decoder #(.N(4), .LOCK_COUNT(3), .ALLOW_HOLD(1)) dut_hold (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .code(code), .clear_err(clear_err),
    .phase(phase_o[0]), .phase_valid(pv_o[0]), .illegal(ill_o[0]), .seq_err(seq_o[0]),
    .wrap(wrap_o[0]), .locked(lock_o[0]), .err_count(err_o[0])
  );

  johnson_decoder #(.N(4), .LOCK_COUNT(3), .ALLOW_HOLD(0)) dut_nohold (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .code(code), .clear_err(clear_err),
    .phase(phase_o[1]), .phase_valid(pv_o[1]), .illegal(ill_o[1]), .seq_err(seq_o[1]),
    .wrap(wrap_o[1]), .locked(lock_o[1]), .err_count(err_o[1])
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  // Legal sequence generated from the shift rule; position in it is the phase.
  logic [3:0] jtab [8];

  // Reference model: 0 = hunting, 1 = checking, 2 = locked.
  int m_mode [2];
  int m_good [2];
  int m_ph   [2];
  int m_err  [2];
  int e_pv [2], e_ill [2], e_seq [2], e_wrap [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input int i, input bit hold_ok, input bit rst, input bit v,
                       input logic [3:0] c, input bit clr);
    int idx;
    bit succ, hold;
    e_pv[i] = 0; e_ill[i] = 0; e_seq[i] = 0; e_wrap[i] = 0;
    if (rst) begin
      m_mode[i] = 0; m_good[i] = 0; m_ph[i] = 0; m_err[i] = 0;
      return;
    end
    if (v) begin
      idx = -1;
      for (int k = 0; k < 8; k++) if (jtab[k] == c) idx = k;
      if (idx < 0) begin
        e_ill[i] = 1; m_mode[i] = 0; m_good[i] = 0;
      end else begin
        e_pv[i] = 1;
        succ = (idx == (m_ph[i] + 1) % 8);
        hold = hold_ok && (idx == m_ph[i]);
        if (m_mode[i] == 0) begin
          m_mode[i] = 1; m_good[i] = 0;
        end else if (m_mode[i] == 1) begin
          if (succ) begin
            m_good[i]++;
            if (m_good[i] == 3) m_mode[i] = 2;
          end else if (!hold) begin
            e_seq[i] = 1; m_good[i] = 0;
          end
        end else begin
          if (succ) e_wrap[i] = (m_ph[i] == 7 && idx == 0);
          else if (!hold) begin
            e_seq[i] = 1; m_good[i] = 0; m_mode[i] = 1;
          end
        end
        m_ph[i] = idx;
      end
    end
    if (clr) m_err[i] = 0;
    else if ((e_ill[i] || e_seq[i]) && m_err[i] < 255) m_err[i]++;
  endtask

  task automatic step(input bit v, input logic [3:0] c, input bit clr = 1'b0,
                      input bit rst = 1'b0);
    @(negedge clk);
    rst_n = ~rst; in_valid = v; code = c; clear_err = clr;
    @(posedge clk);
    model(0, 1'b1, rst, v, c, clr);
    model(1, 1'b0, rst, v, c, clr);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("i%0d phase", i),  32'(phase_o[i]), 32'(m_ph[i]));
      chk($sformatf("i%0d pvalid", i), 32'(pv_o[i]),    32'(e_pv[i]));
      chk($sformatf("i%0d illegal", i), 32'(ill_o[i]),  32'(e_ill[i]));
      chk($sformatf("i%0d seq_err", i), 32'(seq_o[i]),  32'(e_seq[i]));
      chk($sformatf("i%0d wrap", i),   32'(wrap_o[i]),  32'(e_wrap[i]));
      chk($sformatf("i%0d locked", i), 32'(lock_o[i]),  32'(m_mode[i] == 2));
      chk($sformatf("i%0d err_count", i), 32'(err_o[i]), 32'(m_err[i]));
    end
  endtask

  task automatic ph(input int p);
    step(1'b1, jtab[p % 8]);
  endtask

  initial begin
    int r, p;
    jtab[0] = 4'b0000;
    for (int k = 1; k < 8; k++) jtab[k] = {jtab[k-1][2:0], ~jtab[k-1][3]};

    // Reset state
    step(1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    // Acquire lock from zero, then run through a wrap
    for (int k = 0; k < 4; k++) ph(k);
    chk("lock after 0111", 32'(lock_o[0]), 32'd1);
    for (int k = 4; k < 9; k++) ph(k);
    chk("wrap on 7->0", 32'(wrap_o[0]), 32'd1);
    // Illegal code while locked, then relock
    step(1'b1, 4'b0101);
    chk("illegal pulse", 32'(ill_o[0]), 32'd1);
    for (int k = 2; k < 6; k++) ph(k);
    // Skip while locked at phase 2
    for (int k = 6; k < 11; k++) ph(k);
    ph(4);
    chk("skip seq_err", 32'(seq_o[0]), 32'd1);
    // Relock then hold three cycles
    for (int k = 5; k < 11; k++) ph(k);
    ph(2); ph(2); ph(2);
    chk("hold keeps lock", 32'(lock_o[0]), 32'd1);
    // Idle cycles ignore code
    step(1'b0, 4'b0101);
    step(1'b0, 4'b1111);
    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom % 32);
      p = m_ph[0];
      if (r < 18)      ph(p + 1);
      else if (r < 22) ph(p);
      else if (r < 25) ph(int'($urandom % 8));
      else if (r < 28) step(1'b1, 4'($urandom), 1'b0);
      else if (r < 31) step(1'b0, 4'($urandom), 1'b0);
      else             step(1'b1, 4'($urandom), 1'b1);
    end
    // Saturation and clear
    for (int n = 0; n < 300; n++) step(1'b1, 4'b1010);
    chk("err saturated", 32'(err_o[0]), 32'd255);
    step(1'b1, 4'b0101, 1'b1);
    chk("clear wins", 32'(err_o[0]), 32'd0);
    // Relock, then reset mid-lock
    for (int k = 0; k < 6; k++) ph(k);
    step(1'b1, jtab[6], 1'b0, 1'b1);
    ph(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
